ball_motion_ctrl: RTL and testbench

Frame-synchronous motion controller for the bouncing-ball VGA demo. It sits directly upstream of the ball renderer and produces the registered ball centre (`ball_x`, `ball_y`) that the renderer compares against `hpos`/`vpos`. Once per enabled frame it steps the ball by a programmable number of pixels, reflecting off a rectangular bounding box. All updates finish inside vertical blanking, so the renderer never sees a position change mid-frame.

---
 rtl/ball_motion_ctrl.sv | 148 ++++++++++++++
 tb/tb_ball_motion_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ball_motion_ctrl.sv
// Frame-synchronous bouncing-ball motion controller: steps the ball centre once per enabled frame inside a bounding box.
// Optional saturating bounce counter is built when BALL_MOTION_BOUNCE_CNT_EN is defined.
module ball_motion_ctrl #(
  parameter int H_MIN     = 100,
  parameter int H_MAX     = 540,
  parameter int V_MIN     = 100,
  parameter int V_MAX     = 380,
  parameter int X_INIT    = 320,
  parameter int Y_INIT    = 240,
  parameter int FRAME_DIV = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       pause,
  input  logic [2:0] speed,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       dir_x,
  output logic       dir_y,
  output logic       busy,
  output logic       bounce,
  output logic [7:0] bounce_count
);

  localparam logic [9:0] H_MIN_C  = 10'(H_MIN);
  localparam logic [9:0] H_MAX_C  = 10'(H_MAX);
  localparam logic [9:0] V_MIN_C  = 10'(V_MIN);
  localparam logic [9:0] V_MAX_C  = 10'(V_MAX);
  localparam logic [9:0] X_INIT_C = 10'(X_INIT);
  localparam logic [9:0] Y_INIT_C = 10'(Y_INIT);
  localparam logic [7:0] DIV_LAST = 8'(FRAME_DIV - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, STEP = 1'b1} state_t;

  state_t     state_r;
  logic [9:0] ball_x_r, ball_y_r;
  logic       dir_x_r, dir_y_r, busy_r, bounce_r;
  logic [7:0] frame_cnt_r;
  logic [2:0] steps_left_r;

  logic [9:0] nx_s, ny_s;
  logic       ndir_x_s, ndir_y_s, flip_x_s, flip_y_s;
  logic       tick_live_s, frame_wrap_s;

  // One-pixel step on one axis; returns {flip, new_dir, new_pos}.
  function automatic logic [11:0] step_axis(input logic [9:0] pos, input logic dir,
                                            input logic [9:0] lo, input logic [9:0] hi);
    logic [11:0] res;
    if (dir && (pos >= hi)) begin
      res = {1'b1, 1'b0, pos - 10'd1};
    end else if (!dir && (pos <= lo)) begin
      res = {1'b1, 1'b1, pos + 10'd1};
    end else if (dir) begin
      res = {1'b0, 1'b1, pos + 10'd1};
    end else begin
      res = {1'b0, 1'b0, pos - 10'd1};
    end
    return res;
  endfunction

  // Next-step position/direction for both axes plus divider decode.
  always_comb begin
    {flip_x_s, ndir_x_s, nx_s} = step_axis(ball_x_r, dir_x_r, H_MIN_C, H_MAX_C);
    {flip_y_s, ndir_y_s, ny_s} = step_axis(ball_y_r, dir_y_r, V_MIN_C, V_MAX_C);
    tick_live_s  = frame_tick & ~pause;
    frame_wrap_s = (frame_cnt_r == DIV_LAST);
  end

  // Motion FSM, frame divider and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      ball_x_r     <= X_INIT_C;
      ball_y_r     <= Y_INIT_C;
      dir_x_r      <= 1'b1;
      dir_y_r      <= 1'b1;
      busy_r       <= 1'b0;
      bounce_r     <= 1'b0;
      frame_cnt_r  <= 8'd0;
      steps_left_r <= 3'd0;
    end else begin
      bounce_r <= 1'b0;
      // Divider keeps counting ticks during a burst; only IDLE may load one.
      if (tick_live_s) begin
        frame_cnt_r <= frame_wrap_s ? 8'd0 : frame_cnt_r + 8'd1;
      end else begin
        frame_cnt_r <= frame_cnt_r;
      end
      case (state_r)
        IDLE: begin
          if (tick_live_s && frame_wrap_s && (speed != 3'd0)) begin
            steps_left_r <= speed;
            state_r      <= STEP;
            busy_r       <= 1'b1;
          end else begin
            busy_r <= 1'b0;
          end
        end
        STEP: begin
          ball_x_r     <= nx_s;
          ball_y_r     <= ny_s;
          dir_x_r      <= ndir_x_s;
          dir_y_r      <= ndir_y_s;
          bounce_r     <= flip_x_s | flip_y_s;
          steps_left_r <= steps_left_r - 3'd1;
          if (steps_left_r == 3'd1) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else begin
            busy_r <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

`ifdef BALL_MOTION_BOUNCE_CNT_EN
  logic [7:0] bounce_cnt_r;

  // Saturating count of direction flips, updated with the causing step.
  always_ff @(posedge clk) begin
    if (reset) begin
      bounce_cnt_r <= 8'd0;
    end else if ((state_r == STEP) && (flip_x_s | flip_y_s) && (bounce_cnt_r != 8'd255)) begin
      bounce_cnt_r <= bounce_cnt_r + 8'd1;
    end else begin
      bounce_cnt_r <= bounce_cnt_r;
    end
  end

  assign bounce_count = bounce_cnt_r;
`else
  assign bounce_count = 8'd0;
`endif

  assign ball_x = ball_x_r;
  assign ball_y = ball_y_r;
  assign dir_x  = dir_x_r;
  assign dir_y  = dir_y_r;
  assign busy   = busy_r;
  assign bounce = bounce_r;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Directed bench for ball_motion_ctrl: four parameterisations sharing clock, reset and speed.
module tb_ball_motion_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] speed = 3'd0;
  logic       no_pause = 1'b0;
  logic       tick_d = 1'b0, tick_w = 1'b0, tick_c = 1'b0, tick_v = 1'b0;
  logic       pause_v = 1'b0;

  logic [9:0] x_d, y_d, x_w, y_w, x_c, y_c, x_v, y_v;
  logic       dx_d, dy_d, dx_w, dy_w, dx_c, dy_c, dx_v, dy_v;
  logic       busy_d, busy_w, busy_c, busy_v;
  logic       bnc_d, bnc_w, bnc_c, bnc_v;
  logic [7:0] cnt_d, cnt_w, cnt_c, cnt_v;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ball_motion_ctrl u_def (
    .clk(clk), .reset(reset), .frame_tick(tick_d), .pause(no_pause), .speed(speed),
    .ball_x(x_d), .ball_y(y_d), .dir_x(dx_d), .dir_y(dy_d),
    .busy(busy_d), .bounce(bnc_d), .bounce_count(cnt_d));

  ball_motion_ctrl #(.X_INIT(539)) u_wall (
    .clk(clk), .reset(reset), .frame_tick(tick_w), .pause(no_pause), .speed(speed),
    .ball_x(x_w), .ball_y(y_w), .dir_x(dx_w), .dir_y(dy_w),
    .busy(busy_w), .bounce(bnc_w), .bounce_count(cnt_w));

  ball_motion_ctrl #(.X_INIT(540), .Y_INIT(380)) u_corner (
    .clk(clk), .reset(reset), .frame_tick(tick_c), .pause(no_pause), .speed(speed),
    .ball_x(x_c), .ball_y(y_c), .dir_x(dx_c), .dir_y(dy_c),
    .busy(busy_c), .bounce(bnc_c), .bounce_count(cnt_c));

  ball_motion_ctrl #(.FRAME_DIV(4)) u_div (
    .clk(clk), .reset(reset), .frame_tick(tick_v), .pause(pause_v), .speed(speed),
    .ball_x(x_v), .ball_y(y_v), .dir_x(dx_v), .dir_y(dy_v),
    .busy(busy_v), .bounce(bnc_v), .bounce_count(cnt_v));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  int nb, nbn;
  logic [7:0] exp_cnt;

  initial begin
`ifdef BALL_MOTION_BOUNCE_CNT_EN
    exp_cnt = 8'd1;
`else
    exp_cnt = 8'd0;
`endif
    // Reset state
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    check("rst_x", x_d, 320);
    check("rst_y", y_d, 240);
    check("rst_dirs", {dx_d, dy_d}, 2'b11);
    check("rst_busy", busy_d, 0);
    check("rst_bounce", bnc_d, 0);
    check("rst_cnt", cnt_d, 0);

    // Straight step, speed 3
    speed = 3'd3;
    tick_d = 1'b1; cyc(); tick_d = 1'b0;
    check("str_x_t1", x_d, 320);
    nb = 0; nbn = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy_d) nb++;
      if (bnc_d) nbn++;
      cyc();
    end
    check("str_busy_len", nb, 3);
    check("str_bounce", nbn, 0);
    check("str_x", x_d, 323);
    check("str_y", y_d, 243);
    check("str_dirs", {dx_d, dy_d}, 2'b11);

    // Right-wall bounce
    tick_w = 1'b1; cyc(); tick_w = 1'b0;
    cyc();
    check("wall_x1", x_w, 540);
    check("wall_dx1", dx_w, 1);
    check("wall_b1", bnc_w, 0);
    cyc();
    check("wall_x2", x_w, 539);
    check("wall_dx2", dx_w, 0);
    check("wall_b2", bnc_w, 1);
    check("wall_cnt", cnt_w, exp_cnt);
    cyc();
    check("wall_x3", x_w, 538);
    check("wall_b3", bnc_w, 0);
    check("wall_busy_end", busy_w, 0);

    // Corner bounce, speed 1
    speed = 3'd1;
    tick_c = 1'b1; cyc(); tick_c = 1'b0;
    check("corner_busy", busy_c, 1);
    cyc();
    check("corner_x", x_c, 539);
    check("corner_y", y_c, 379);
    check("corner_dirs", {dx_c, dy_c}, 2'b00);
    check("corner_b", bnc_c, 1);
    check("corner_cnt", cnt_c, exp_cnt);
    cyc();
    check("corner_b_off", bnc_c, 0);
    check("corner_cnt_hold", cnt_c, exp_cnt);

    // Divider: burst only on the 4th tick
    for (int t = 1; t <= 4; t++) begin
      tick_v = 1'b1; cyc(); tick_v = 1'b0;
      check($sformatf("div_busy_tick%0d", t), busy_v, (t == 4) ? 1 : 0);
      cyc(); cyc();
    end
    check("div_x", x_v, 321);
    check("div_y", y_v, 241);
    // Paused: ticks ignored
    pause_v = 1'b1;
    nb = 0;
    for (int t = 0; t < 10; t++) begin
      tick_v = 1'b1; cyc(); tick_v = 1'b0;
      if (busy_v) nb++;
      cyc();
      if (busy_v) nb++;
    end
    check("pause_busy", nb, 0);
    check("pause_x", x_v, 321);
    pause_v = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      tick_v = 1'b1; cyc(); tick_v = 1'b0;
      check($sformatf("unpause_busy_tick%0d", t), busy_v, (t == 4) ? 1 : 0);
      cyc(); cyc();
    end
    check("unpause_x", x_v, 322);

    // Reset mid-burst, speed 7
    speed = 3'd7;
    tick_d = 1'b1; cyc(); tick_d = 1'b0;
    cyc(); cyc();
    check("mid_busy_step3", busy_d, 1);
    reset = 1'b1; cyc(); reset = 1'b0;
    check("mid_rst_x", x_d, 320);
    check("mid_rst_y", y_d, 240);
    check("mid_rst_busy", busy_d, 0);
    cyc();
    tick_d = 1'b1; cyc(); tick_d = 1'b0;
    speed = 3'd1;
    nb = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy_d) nb++;
      cyc();
    end
    check("fresh_busy_len", nb, 7);
    check("fresh_x", x_d, 327);
    check("fresh_y", y_d, 247);

    // Speed 0: no burst
    speed = 3'd0;
    nb = 0;
    for (int t = 0; t < 3; t++) begin
      tick_d = 1'b1; cyc(); tick_d = 1'b0;
      if (busy_d) nb++;
      cyc();
      if (busy_d) nb++;
    end
    check("spd0_busy", nb, 0);
    check("spd0_x", x_d, 327);
    check("spd0_y", y_d, 247);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
